// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operand width,
// op encodings, FSM states and the per-iteration algorithm select.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_DIVU  = 2'd1;
  localparam logic [1:0] OP_MTHI  = 2'd2;
  localparam logic [1:0] OP_MTLO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mdu_mode_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// In divide mode the accumulator is {remainder, quotient}; the new quotient
// bit is returned separately and its slot in acc_o is left at zero.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mdu_mode_t          mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic               mplier_lsb_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               dvd_bit_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remSh;
  logic [WIDTH+1:0] trial;

  // Both datapaths are computed each cycle; the mode picks which one advances.
  // The trial subtraction carries one extra bit so the remainder bit shifted
  // out of the top still takes part in the compare.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
           + (mplier_lsb_i ? {1'b0, mcand_i} : {(WIDTH+1){1'b0}});
    remSh  = {acc_i[2*WIDTH-1:WIDTH], dvd_bit_i};
    trial  = {1'b0, remSh} - {2'b00, divisor_i};
    qbit_o = ~trial[WIDTH+1];
    if (mode_i == MODE_MUL) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {(qbit_o ? trial[WIDTH-1:0] : remSh[WIDTH-1:0]),
               acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer owning HI/LO. MTHI/MTLO write in one
// cycle; MULTU/DIVU take WIDTH iterations and hold the front of the pipe
// through stall until the result is committed.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t         state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dz_q;

  mdu_mode_t          stepMode;
  logic [2*WIDTH-1:0] stepAcc;
  logic               qBit;
  logic [2*WIDTH-1:0] acc_d;
  logic               issue;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode_i       (stepMode),
    .acc_i        (acc_q),
    .mcand_i      (a_q),
    .mplier_lsb_i (b_q[0]),
    .divisor_i    (b_q),
    .dvd_bit_i    (a_q[WIDTH-1]),
    .acc_o        (stepAcc),
    .qbit_o       (qBit)
  );

  // Step mode, next accumulator with the quotient bit dropped in, and the
  // combinational request-cycle part of the stall.
  always_comb begin
    stepMode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;
    acc_d    = {stepAcc[2*WIDTH-1:1], (state_q == ST_DIV) ? qBit : stepAcc[0]};
    issue    = (state_q == ST_IDLE) && start && !op[1] && !flush;
    stall    = issue || (state_q == ST_MUL) || (state_q == ST_DIV);
    busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
  end

  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Sequencer FSM: issue/MT writes in IDLE, iterate in MUL/DIV, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULTU, OP_DIVU: begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                cnt_q   <= '0;
                acc_q   <= '0;
                state_q <= (op == OP_MULTU) ? ST_MUL : ST_DIV;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            if (state_q == ST_MUL) begin
              b_q <= b_q >> 1;
            end else begin
              a_q <= a_q << 1;
            end
            if (cnt_q == 6'(WIDTH - 1)) begin
              {hi_q, lo_q} <= acc_d;
              done_q       <= 1'b1;
              dz_q         <= (state_q == ST_DIV) && (b_q == '0);
              state_q      <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal results plus
// randomized traffic against a cycle-level behavioural model of HI/LO.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;

  // Behavioural model: cycles still in flight, DONE flag, HI/LO and operands.
  int           mLeft = 0;
  bit           mDone = 1'b0;
  bit           mDz   = 1'b0;
  logic [W-1:0] mHi   = '0;
  logic [W-1:0] mLo   = '0;
  logic [W-1:0] mA    = '0;
  logic [W-1:0] mB    = '0;
  logic [1:0]   mOp   = '0;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .dz     (dz),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advanced on every rising edge from the spec's rules.
  always @(posedge clk) begin
    logic [63:0] prod;
    bit wasDone;
    if (!rst) begin
      mLeft = 0; mDone = 0; mDz = 0; mHi = '0; mLo = '0;
    end else begin
      wasDone = mDone;
      mDone = 0;
      mDz = 0;
      if (mLeft > 0) begin
        if (flush) begin
          mLeft = 0;
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            mDone = 1;
            if (mOp == OP_MULTU) begin
              prod = {32'b0, mA} * {32'b0, mB};
              mHi = prod[63:32];
              mLo = prod[31:0];
            end else if (mB == 0) begin
              mLo = '1; mHi = mA; mDz = 1;
            end else begin
              mLo = mA / mB; mHi = mA % mB;
            end
          end
        end
      end else if (!wasDone && start && !flush) begin
        case (op)
          OP_MULTU, OP_DIVU: begin mLeft = W; mOp = op; mA = rs_val; mB = rt_val; end
          OP_MTHI: mHi = rs_val;
          OP_MTLO: mLo = rs_val;
        endcase
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", stall,
                  (mLeft > 0) || (!mDone && start && op < 2 && !flush));
      checkOutput("busy", busy, mLeft > 0);
      checkOutput("done", done, mDone);
      checkOutput("dz", dz, mDz);
      checkOutput("hi", hi, mHi);
      checkOutput("lo", lo, mLo);
    end
  end

  task automatic applyStimulus(input logic s, input logic [1:0] o,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic f);
    start = s; op = o; rs_val = a; rt_val = b; flush = f;
    @(posedge clk); #1;
    start = 0; flush = 0;
  endtask

  // Issue one MULTU/DIVU and observe 40 cycles: stall count, done cycle, dz.
  task automatic runOp(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int stallCnt,
                       output int doneCyc, output logic dzSeen);
    stallCnt = 0; doneCyc = -1; dzSeen = 0;
    start = 1; op = o; rs_val = a; rt_val = b; flush = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (done) begin doneCyc = k; dzSeen = dz; end
      @(posedge clk); #1;
      start = 0;
    end
  endtask

  initial begin
    int sc, dc;
    logic dzs;
    rst = 0; start = 0; op = 0; rs_val = 0; rt_val = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1;
    checkEn = 1;

    $display("[TB] MULTU max x max");
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, dc, dzs);
    checkOutput("mul_stall_cycles", sc, 33);
    checkOutput("mul_done_cycle", dc, 33);
    checkOutput("mul_hi", hi, 32'hFFFF_FFFE);
    checkOutput("mul_lo", lo, 32'h0000_0001);

    $display("[TB] DIVU 100/7");
    runOp(OP_DIVU, 100, 7, sc, dc, dzs);
    checkOutput("div_done_cycle", dc, 33);
    checkOutput("div_dz", dzs, 0);
    checkOutput("div_lo", lo, 14);
    checkOutput("div_hi", hi, 2);

    $display("[TB] DIVU 5/0");
    runOp(OP_DIVU, 5, 0, sc, dc, dzs);
    checkOutput("dz_done_cycle", dc, 33);
    checkOutput("dz_flag", dzs, 1);
    checkOutput("dz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("dz_hi", hi, 5);

    $display("[TB] MTHI then MTLO");
    start = 1; op = OP_MTHI; rs_val = 32'h1234;
    @(posedge clk); #1;
    op = OP_MTLO; rs_val = 32'hABCD;
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mt_stall", stall, 0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checkOutput("mtlo_lo", lo, 32'hABCD);
    checkOutput("mt_busy", busy, 0);

    $display("[TB] flush mid-MULTU");
    applyStimulus(1, OP_MTHI, 32'h11, 0, 0);
    applyStimulus(1, OP_MTLO, 32'h11, 0, 0);
    applyStimulus(1, OP_MULTU, 3, 4, 0);
    repeat (10) begin @(posedge clk); #1; end
    applyStimulus(0, OP_MULTU, 0, 0, 1);
    @(negedge clk);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_hi", hi, 32'h11);
    checkOutput("flush_lo", lo, 32'h11);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("flush_done", done, 0);
    applyStimulus(1, OP_MTHI, 32'h99, 0, 1);
    applyStimulus(1, OP_MULTU, 5, 5, 1);
    @(negedge clk);
    checkOutput("startflush_hi", hi, 32'h11);
    checkOutput("startflush_busy", busy, 0);
    @(posedge clk); #1;

    $display("[TB] reset mid-DIVU");
    applyStimulus(1, OP_DIVU, 32'hDEAD_BEEF, 3, 0);
    repeat (20) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dz", dz, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    @(posedge clk); #1;
    runOp(OP_MULTU, 6, 7, sc, dc, dzs);
    checkOutput("post_rst_lo", lo, 42);
    checkOutput("post_rst_hi", hi, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      start  = ($urandom % 3) == 0;
      op     = 2'($urandom);
      rs_val = (($urandom % 4) == 0) ? ($urandom % 256) : $urandom;
      rt_val = (($urandom % 8) == 0) ? 0 :
               ((($urandom % 4) == 0) ? ($urandom % 16) : $urandom);
      flush  = ($urandom % 150) == 0;
      @(posedge clk); #1;
    end
    start = 0; flush = 0;
    repeat (40) begin @(posedge clk); #1; end

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
